// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: scan-state type and seven-segment glyph constants for the BCD display scanner
package bcd_disp_pkg;
    typedef enum logic [1:0] {DIG0, DIG1, DIG2} scan_e;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: plain 0-9 nibble to {g,f,e,d,c,b,a} glyph; non-decimal codes are left dark for the parent to override
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    // glyph lookup
    always_comb begin
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: multiplexed three-digit BCD seven-segment driver with leading-zero blanking and sticky error flag
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int DIV      = 50000,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        err
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [11:0]   bcd_q, bcd_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    scan_e         state_q, state_d;
    logic [2:0]    an_q, an_d;
    logic          bad_in;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic          inv;
    logic          blank;

    assign bad_in  = (bcd[3:0] > 4'd9) | (bcd[7:4] > 4'd9) | (bcd[11:8] > 4'd9);
    assign bcd_d   = load ? bcd : bcd_q;
    assign err_d   = err_q | (load & bad_in);
    assign tick    = (cnt_q == CW'(DIV - 1));
    assign cnt_d   = tick ? '0 : cnt_q + CW'(1);
    assign state_d = (state_q == DIG0) ? DIG1 : (state_q == DIG1) ? DIG2 : DIG0;
    assign an_d    = (state_d == DIG0) ? 3'b001 : (state_d == DIG1) ? 3'b010 : 3'b100;

    // capture register and sticky invalid-digit flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            err_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            err_q <= err_d;
        end
    end

    // refresh prescaler, wraps after DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // digit scan FSM with registered one-hot anode enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIG0;
            an_q    <= 3'b001;
        end else if (tick) begin
            state_q <= state_d;
            an_q    <= an_d;
        end
    end

    assign nib = (state_q == DIG0) ? bcd_q[3:0] : (state_q == DIG1) ? bcd_q[7:4] : bcd_q[11:8];

    seg7_decode u_dec (
        .nib_i (nib),
        .seg_o (dec)
    );

    // invalid digits always show a dash so they are never hidden by blanking
    assign inv   = nib > 4'd9;
    assign blank = BLANK_LZ && !inv &&
                   (((state_q == DIG2) && (bcd_q[11:8] == 4'd0)) ||
                    ((state_q == DIG1) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)));
    assign seg   = inv ? SEG_DASH : blank ? SEG_BLANK : dec;
    assign an    = an_q;
    assign err   = err_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: scoreboard bench comparing three scanner configurations against a cycle-count display model
module tb_bcd_display_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [11:0] bcd = '0;
    logic [6:0]  seg4, seg1, segn;
    logic [2:0]  an4, an1, ann;
    logic        err4, err1, errn;

    typedef struct packed {
        logic [2:0] an4;
        logic [2:0] an1;
        logic [6:0] seg4;
        logic [6:0] seg1;
        logic [6:0] segn;
        logic       err;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [11:0] bm = '0;
    logic        em = 1'b0;

    always #5 clk = ~clk;

    bcd_display_scan #(.DIV(4), .BLANK_LZ(1'b1)) u_d4 (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .seg(seg4), .an(an4), .err(err4));
    bcd_display_scan #(.DIV(1), .BLANK_LZ(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .seg(seg1), .an(an1), .err(err1));
    bcd_display_scan #(.DIV(4), .BLANK_LZ(1'b0)) u_dn (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .seg(segn), .an(ann), .err(errn));

    function automatic logic [6:0] exp_seg(input logic [11:0] v, input int dig, input bit blz);
        logic [6:0] tbl [10];
        int h, t, n;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        h = int'(v[11:8]);
        t = int'(v[7:4]);
        n = int'((v >> (4 * dig)) & 12'hF);
        if (n > 9) return 7'h40;
        if (blz && dig == 2 && h == 0) return 7'h00;
        if (blz && dig == 1 && h == 0 && t == 0) return 7'h00;
        return tbl[n];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: drive inputs, let the model follow the edge, queue the expected display
    task automatic step(input bit ld, input logic [11:0] v);
        exp_t e;
        int d4, d1;
        load = ld;
        bcd  = v;
        @(posedge clk);
        if (rst) begin
            cyc = 0;
            bm  = '0;
            em  = 1'b0;
        end else begin
            cyc++;
            if (ld) begin
                bm = v;
                if (v[3:0] > 9 || v[7:4] > 9 || v[11:8] > 9) em = 1'b1;
            end
        end
        d4 = (cyc / 4) % 3;
        d1 = cyc % 3;
        e.an4  = 3'b001 << d4;
        e.an1  = 3'b001 << d1;
        e.seg4 = exp_seg(bm, d4, 1'b1);
        e.seg1 = exp_seg(bm, d1, 1'b1);
        e.segn = exp_seg(bm, d4, 1'b0);
        e.err  = em;
        q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [3:0] rnib();
        return ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    endfunction

    // monitor: the display is presented every cycle, compare away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("an_div4",   {5'b0, an4},  {5'b0, e.an4});
                check("seg_div4",  {1'b0, seg4}, {1'b0, e.seg4});
                check("err_div4",  {7'b0, err4}, {7'b0, e.err});
                check("an_div1",   {5'b0, an1},  {5'b0, e.an1});
                check("seg_div1",  {1'b0, seg1}, {1'b0, e.seg1});
                check("err_div1",  {7'b0, err1}, {7'b0, e.err});
                check("an_noblnk", {5'b0, ann},  {5'b0, e.an4});
                check("seg_noblnk", {1'b0, segn}, {1'b0, e.segn});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [11:0] v;
        @(negedge clk);
        step(0, 12'h000);
        step(0, 12'h000);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(0, 12'h000);
        step(1, 12'h255);
        for (int i = 0; i < 12; i++) step(0, 12'h000);
        step(1, 12'h007);
        for (int i = 0; i < 12; i++) step(0, 12'h000);
        step(1, 12'h0A3);
        for (int i = 0; i < 12; i++) step(0, 12'h000);
        step(1, 12'h123);
        for (int i = 0; i < 12; i++) step(0, 12'h000);
        while ((cyc + 1) % 4 != 0) step(0, 12'h000);
        step(1, 12'h100);
        for (int i = 0; i < 8; i++) step(0, 12'h000);
        for (int i = 0; i < 300; i++) begin
            v = {rnib(), rnib(), rnib()};
            if ($urandom_range(0, 3) == 0) v[11:8] = 4'd0;
            if ($urandom_range(0, 4) == 0) v[7:4]  = 4'd0;
            step($urandom_range(0, 3) == 0, v);
        end
        step(1, 12'hF00);
        step(0, 12'h000);
        #1 rst = 1'b1;
        #1;
        check("async_an_div4",  {5'b0, an4},  8'h01);
        check("async_seg_div4", {1'b0, seg4}, 8'h3F);
        check("async_err_div4", {7'b0, err4}, 8'h00);
        check("async_an_div1",  {5'b0, an1},  8'h01);
        check("async_seg_div1", {1'b0, seg1}, 8'h3F);
        check("async_err_div1", {7'b0, err1}, 8'h00);
        @(negedge clk);
        step(1, 12'h999);
        step(0, 12'h000);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) step(0, 12'h000);
        step(1, 12'h040);
        for (int i = 0; i < 12; i++) step(0, 12'h000);
        #2;
        check("queue_drained", 8'(q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
